// File: rtl/dma_timing_ctrl.sv
// DMA bus timing sequencer: requests the bus, runs S1-S4 transfer cycles with
// wait states, counts words down and ends a service on TC, EOP, single mode or lost HLDA.
module dma_timing_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_any,
  input  logic [1:0]       grant_ch,
  input  logic [CNT_W-1:0] start_count,
  input  logic             block_mode,
  input  logic [1:0]       xfer_type,
  input  logic             HLDA,
  input  logic             READY,
  input  logic             EOP_N_in,
  output logic             HRQ,
  output logic             validDACK,
  output logic [1:0]       act_ch,
  output logic             AEN,
  output logic             ADSTB,
  output logic             MEMR_N,
  output logic             MEMW_N,
  output logic             IOR_N,
  output logic             IOW_N,
  output logic             EOP_N_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             done
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} state_t;

  state_t state, state_nxt;
  logic   ext_eop;
  logic   is_read, is_write;
  logic   src_on, dst_on;
  logic   tc, end_svc;

  always_comb begin
    state_nxt = state;
    is_read   = (xfer_type == 2'b10);
    is_write  = (xfer_type == 2'b01);
    src_on    = (state == S2) || (state == S3) || (state == SW);
    dst_on    = (state == S3) || (state == SW);
    // TC looks at the count on entry to S4; the decrement lands at the S4 edge
    tc        = (state == S4) && (cnt_out == '0);
    end_svc   = (state == S4) && (tc || ext_eop || !block_mode || !HLDA);

    HRQ       = (state != SI);
    validDACK = (state == S1) || src_on || (state == S4);
    AEN       = validDACK;
    ADSTB     = (state == S1);
    MEMR_N    = !(src_on && is_read);
    IOR_N     = !(src_on && is_write);
    IOW_N     = !(dst_on && is_read);
    MEMW_N    = !(dst_on && is_write);
    EOP_N_out = !tc;

    unique case (state)
      SI: if (req_any) state_nxt = S0;
      S0: begin
        if (HLDA)          state_nxt = S1;
        else if (!req_any) state_nxt = SI;
      end
      S1: state_nxt = S2;
      S2: state_nxt = S3;
      S3: state_nxt = READY ? S4 : SW;
      SW: if (READY) state_nxt = S4;
      S4: state_nxt = end_svc ? SI : S1;
      default: state_nxt = SI;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= SI;
      act_ch  <= '0;
      cnt_out <= '0;
      ext_eop <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= end_svc;
      if (state == S0 && HLDA) begin
        act_ch  <= grant_ch;
        cnt_out <= start_count;
        ext_eop <= 1'b0;
      end
      if (src_on && !EOP_N_in)
        ext_eop <= 1'b1;
      if (state == S4) begin
        cnt_out <= cnt_out - CNT_W'(1);
        if (end_svc)
          ext_eop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl; write-back results are checked through a
// scoreboard queue filled when each service is launched and drained on done.
module tb_dma_timing_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_any;
  logic [1:0]  grant_ch;
  logic [15:0] start_count;
  logic        block_mode;
  logic [1:0]  xfer_type;
  logic        HLDA, READY, EOP_N_in;
  logic        HRQ, validDACK, AEN, ADSTB;
  logic [1:0]  act_ch;
  logic        MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, done;
  logic [15:0] cnt_out;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  dma_timing_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .req_any(req_any), .grant_ch(grant_ch),
    .start_count(start_count), .block_mode(block_mode), .xfer_type(xfer_type),
    .HLDA(HLDA), .READY(READY), .EOP_N_in(EOP_N_in), .HRQ(HRQ),
    .validDACK(validDACK), .act_ch(act_ch), .AEN(AEN), .ADSTB(ADSTB),
    .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N_out(EOP_N_out), .cnt_out(cnt_out), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {MEMR_N, MEMW_N, IOR_N, IOW_N}; phase 0 = none, 1 = source only, 2 = source + destination
  function automatic logic [3:0] exp_strobe(input logic [1:0] xt, input int phase);
    if (phase == 0) return 4'b1111;
    if (xt == 2'b10) return (phase == 1) ? 4'b0111 : 4'b0110;
    if (xt == 2'b01) return (phase == 1) ? 4'b1101 : 4'b1001;
    return 4'b1111;
  endfunction

  function automatic logic [3:0] strobes();
    return {MEMR_N, MEMW_N, IOR_N, IOW_N};
  endfunction

  always @(negedge CLK) begin
    if (!RESET && done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cnt", cnt_out, e.cnt);
        chk("wb_ch", act_ch, e.ch);
      end
    end
  end

  // One full service from SI back to SI; eop_xfer/wait_xfer are transfer indices or -1.
  task automatic service(input logic [1:0] ch, input logic [15:0] start, input logic blk,
                         input logic [1:0] xt, input int eop_xfer, input int wait_xfer,
                         input int nwait);
    int   n;
    int   cycles;
    int   exp_cycles;
    exp_t e;
    n = blk ? int'(start) + 1 : 1;
    if (eop_xfer >= 0 && eop_xfer + 1 < n) n = eop_xfer + 1;
    e.ch  = ch;
    e.cnt = start - 16'(n);
    sb.push_back(e);
    exp_cycles = 4 * n + ((wait_xfer >= 0 && wait_xfer < n) ? nwait : 0);

    grant_ch = ch; start_count = start; block_mode = blk; xfer_type = xt;
    req_any = 1'b1;
    tick();
    chk("s0_hrq", HRQ, 1);
    chk("s0_aen", AEN, 0);
    HLDA = 1'b1;
    tick();
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      chk("s1_adstb", ADSTB, 1);
      chk("s1_dack", {AEN, validDACK}, 2'b11);
      chk("s1_act_ch", act_ch, ch);
      chk("s1_strobes", strobes(), 4'b1111);
      grant_ch = ch + 2'd1;
      tick(); cycles++;
      chk("s2_adstb", ADSTB, 0);
      chk("s2_strobes", strobes(), exp_strobe(xt, 1));
      if (i == eop_xfer) EOP_N_in = 1'b0;
      if (i == n - 1) begin
        HLDA = 1'b0;
        req_any = 1'b0;
      end
      tick(); cycles++;
      EOP_N_in = 1'b1;
      chk("s3_strobes", strobes(), exp_strobe(xt, 2));
      if (i == wait_xfer && nwait > 0) READY = 1'b0;
      tick(); cycles++;
      if (i == wait_xfer) begin
        for (int w = 0; w < nwait; w++) begin
          chk("sw_strobes", strobes(), exp_strobe(xt, 2));
          chk("sw_aen", AEN, 1);
          if (w == nwait - 1) READY = 1'b1;
          tick(); cycles++;
        end
      end
      chk("s4_strobes", strobes(), 4'b1111);
      chk("s4_cnt", cnt_out, start - 16'(i));
      chk("s4_eop_n", EOP_N_out, (16'(i) == start) ? 1'b0 : 1'b1);
      chk("s4_dack", validDACK, 1);
      tick(); cycles++;
    end
    chk("svc_cycles", cycles, exp_cycles);
    chk("end_done", done, 1);
    chk("end_hrq", HRQ, 0);
    chk("end_dack", {AEN, validDACK}, 2'b00);
    chk("end_eop_n", EOP_N_out, 1);
    tick();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    RESET = 1'b1; req_any = 1'b0; grant_ch = 2'd0; start_count = 16'd0;
    block_mode = 1'b0; xfer_type = 2'b00; HLDA = 1'b0; READY = 1'b1; EOP_N_in = 1'b1;
    #3;
    chk("rst_ctl", {HRQ, validDACK, AEN, ADSTB, done}, 5'b00000);
    chk("rst_strobes", {strobes(), EOP_N_out}, 5'b11111);
    chk("rst_cnt_ch", {act_ch, cnt_out}, 18'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    tick();

    // single read, TC on the only transfer
    service(2'd2, 16'd0, 1'b0, 2'b10, -1, -1, 0);
    // block write of three words, TC on the third
    service(2'd1, 16'd2, 1'b1, 2'b01, -1, -1, 0);
    // single read with three wait states, no TC
    service(2'd3, 16'd7, 1'b0, 2'b10, -1, 0, 3);
    // block read terminated by external EOP in the second transfer
    service(2'd0, 16'd5, 1'b1, 2'b10, 1, -1, 0);
    // verify type 11 drives no strobes
    service(2'd1, 16'd1, 1'b0, 2'b11, -1, -1, 0);
    // block write wrapping through a larger count with a wait in the middle
    service(2'd2, 16'd3, 1'b1, 2'b01, -1, 2, 1);

    // request withdrawn in S0
    req_any = 1'b1;
    tick();
    chk("abort_s0_hrq", HRQ, 1);
    req_any = 1'b0;
    tick();
    chk("abort_hrq", HRQ, 0);
    chk("abort_adstb", ADSTB, 0);
    HLDA = 1'b1;
    tick();
    chk("abort_idle", {HRQ, AEN, ADSTB, strobes()}, 7'b000_1111);
    HLDA = 1'b0;

    // asynchronous reset while in SW
    grant_ch = 2'd3; start_count = 16'd4; block_mode = 1'b1; xfer_type = 2'b10;
    req_any = 1'b1;
    tick();
    HLDA = 1'b1;
    tick();
    tick();
    READY = 1'b0;
    tick();
    tick();
    chk("pre_rst_sw", {strobes(), AEN}, 5'b0110_1);
    chk("pre_rst_cnt", cnt_out, 16'd4);
    #2 RESET = 1'b1;
    #1;
    chk("arst_ctl", {HRQ, validDACK, AEN, ADSTB, done}, 5'b00000);
    chk("arst_strobes", {strobes(), EOP_N_out}, 5'b11111);
    chk("arst_cnt_ch", {act_ch, cnt_out}, 18'd0);
    req_any = 1'b0; HLDA = 1'b0; READY = 1'b1;
    @(posedge CLK); #3;
    chk("arst_hold", {HRQ, strobes()}, 5'b0_1111);
    RESET = 1'b0;
    tick();
    chk("post_rst_idle", {HRQ, AEN, done}, 3'b000);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
